xc_malu_mul_seq: RTL and testbench

XC_MALU_MUL_SEQ -- requirements
Module: xc_malu_mul_seq

---
 rtl/xc_malu_pkg.sv | 28 ++
 rtl/xc_malu_mul.sv | 50 +++++
 rtl/xc_malu_mul_seq.sv | 129 ++++++++++++
 tb/tb_xc_malu_mul_seq.sv | 181 ++++++++++++++++++
 4 files changed

// File: rtl/xc_malu_pkg.sv
// rtl/xc_malu_pkg.sv - shared encodings for the sequential multiplier
package xc_malu_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } mul_state_t;

    localparam logic [5:0] MUL_STEPS = 6'd32;

    localparam int OP_MUL    = 0;
    localparam int OP_MULH   = 1;
    localparam int OP_MULHU  = 2;
    localparam int OP_MULHSU = 3;
    localparam int OP_CLMUL  = 4;
    localparam int OP_CLMULH = 5;

    function automatic logic is_onehot6(input logic [5:0] v);
        logic [2:0] n;
        n = 3'd0;
        for (int i = 0; i < 6; i++) begin
            n = n + {2'b00, v[i]};
        end
        return n == 3'd1;
    endfunction

endpackage

// File: rtl/xc_malu_mul.sv
// rtl/xc_malu_mul.sv - one shift-add step of the multiplier, using an external packed adder
module xc_malu_mul
    import xc_malu_pkg::*;
(
    input  logic [63:0] acc,
    input  logic [31:0] arg_0,
    input  logic [5:0]  count,
    input  logic [31:0] rs1,
    input  logic        carryless,
    input  logic        lhs_sign,
    input  logic        rhs_sign,
    output logic [31:0] padd_lhs,
    output logic [31:0] padd_rhs,
    output logic        padd_sub,
    output logic        padd_cin,
    output logic        padd_cen,
    input  logic [31:0] padd_cout,
    input  logic [31:0] padd_result,
    output logic [63:0] n_acc,
    output logic [31:0] n_arg_0
);

    logic add_en;
    logic ext_lhs;
    logic ext_rhs_raw;
    logic ext_rhs;
    logic top_bit;
    logic unused_acc_lsb;
    logic unused_cout;

    // A signed multiplier's MSB carries negative weight, so the last partial product is subtracted.
    assign add_en      = arg_0[0];
    assign padd_sub    = add_en && rhs_sign && (count == MUL_STEPS - 6'd1);
    assign padd_cin    = padd_sub;
    assign padd_cen    = !carryless;
    assign padd_lhs    = acc[63:32];
    assign padd_rhs    = add_en ? rs1 : 32'd0;

    assign ext_lhs     = lhs_sign && acc[63];
    assign ext_rhs_raw = add_en && lhs_sign && rs1[31];
    assign ext_rhs     = padd_sub ? !ext_rhs_raw : ext_rhs_raw;
    assign top_bit     = ext_lhs ^ ext_rhs ^ padd_cout[31];

    assign n_acc       = {top_bit, padd_result, acc[31:1]};
    assign n_arg_0     = {1'b0, arg_0[31:1]};

    assign unused_acc_lsb = acc[0];
    assign unused_cout    = ^padd_cout[30:0];

endmodule

// File: rtl/xc_malu_mul_seq.sv
// rtl/xc_malu_mul_seq.sv - 32-step sequential multiplier for mul/mulh*/clmul* ops
module xc_malu_mul_seq
    import xc_malu_pkg::*;
(
    input  logic        g_clk,
    input  logic        g_resetn,
    input  logic        valid,
    input  logic        flush,
    input  logic [31:0] rs1,
    input  logic [31:0] rs2,
    input  logic        op_mul,
    input  logic        op_mulh,
    input  logic        op_mulhu,
    input  logic        op_mulhsu,
    input  logic        op_clmul,
    input  logic        op_clmulh,
    output logic        ready,
    output logic [31:0] result,
    output logic        busy
);

    mul_state_t  state, n_state;
    logic [63:0] acc, n_acc, step_acc;
    logic [31:0] arg_0, n_arg_0, step_arg_0;
    logic [5:0]  count, n_count;
    logic [5:0]  ops;
    logic        ops_ok;
    logic        carryless, lhs_sign, rhs_sign;

    logic [31:0] padd_lhs, padd_rhs, padd_rhs_eff, padd_result, padd_cout;
    logic        padd_sub, padd_cin, padd_cen;

    assign ops[OP_MUL]    = op_mul;
    assign ops[OP_MULH]   = op_mulh;
    assign ops[OP_MULHU]  = op_mulhu;
    assign ops[OP_MULHSU] = op_mulhsu;
    assign ops[OP_CLMUL]  = op_clmul;
    assign ops[OP_CLMULH] = op_clmulh;
    assign ops_ok         = is_onehot6(ops);

    assign carryless = op_clmul | op_clmulh;
    assign lhs_sign  = op_mulh | op_mulhsu;
    assign rhs_sign  = op_mulh;

    xc_malu_mul u_mul (
        .acc         (acc),
        .arg_0       (arg_0),
        .count       (count),
        .rs1         (rs1),
        .carryless   (carryless),
        .lhs_sign    (lhs_sign),
        .rhs_sign    (rhs_sign),
        .padd_lhs    (padd_lhs),
        .padd_rhs    (padd_rhs),
        .padd_sub    (padd_sub),
        .padd_cin    (padd_cin),
        .padd_cen    (padd_cen),
        .padd_cout   (padd_cout),
        .padd_result (padd_result),
        .n_acc       (step_acc),
        .n_arg_0     (step_arg_0)
    );

    // Packed adder: lhs + (sub ? ~rhs : rhs) + cin; cen low kills every carry, leaving XOR.
    always_comb begin
        logic carry;
        padd_rhs_eff = padd_sub ? ~padd_rhs : padd_rhs;
        padd_result  = 32'd0;
        padd_cout    = 32'd0;
        carry        = padd_cin;
        for (int i = 0; i < 32; i++) begin
            padd_result[i] = padd_lhs[i] ^ padd_rhs_eff[i] ^ carry;
            padd_cout[i]   = padd_cen & ((padd_lhs[i] & padd_rhs_eff[i]) |
                                         (carry & (padd_lhs[i] ^ padd_rhs_eff[i])));
            carry          = padd_cout[i];
        end
    end

    always_comb begin
        n_state = state;
        n_acc   = acc;
        n_arg_0 = arg_0;
        n_count = count;
        case (state)
            ST_IDLE: begin
                if (!flush && valid) begin
                    n_acc   = 64'd0;
                    n_arg_0 = rs2;
                    n_count = 6'd0;
                    n_state = ops_ok ? ST_RUN : ST_DONE;
                end
            end
            ST_RUN: begin
                if (flush) begin
                    n_state = ST_IDLE;
                end else begin
                    n_acc   = step_acc;
                    n_arg_0 = step_arg_0;
                    n_count = count + 6'd1;
                    if (count == MUL_STEPS - 6'd1) begin
                        n_state = ST_DONE;
                    end
                end
            end
            ST_DONE: n_state = ST_IDLE;
            default: n_state = ST_IDLE;
        endcase
    end

    always_ff @(posedge g_clk) begin
        if (!g_resetn) begin
            state <= ST_IDLE;
            acc   <= 64'd0;
            arg_0 <= 32'd0;
            count <= 6'd0;
        end else begin
            state <= n_state;
            acc   <= n_acc;
            arg_0 <= n_arg_0;
            count <= n_count;
        end
    end

    assign ready  = (state == ST_DONE) && !flush;
    assign busy   = (state != ST_IDLE);
    assign result = !ready            ? 32'd0 :
                    (op_mul | op_clmul) ? acc[31:0] : acc[63:32];

endmodule

// File: tb/tb_xc_malu_mul_seq.sv
// tb/tb_xc_malu_mul_seq.sv - scoreboard bench for the sequential multiplier
module tb_xc_malu_mul_seq;

    logic        g_clk = 1'b0;
    logic        g_resetn;
    logic        valid;
    logic        flush;
    logic [31:0] rs1, rs2;
    logic [5:0]  ops;
    logic        ready, busy;
    logic [31:0] result;

    int tests = 0;
    int fails = 0;
    logic [31:0] exp_q[$];

    always #5 g_clk = ~g_clk;

    xc_malu_mul_seq dut (
        .g_clk     (g_clk),
        .g_resetn  (g_resetn),
        .valid     (valid),
        .flush     (flush),
        .rs1       (rs1),
        .rs2       (rs2),
        .op_mul    (ops[0]),
        .op_mulh   (ops[1]),
        .op_mulhu  (ops[2]),
        .op_mulhsu (ops[3]),
        .op_clmul  (ops[4]),
        .op_clmulh (ops[5]),
        .ready     (ready),
        .result    (result),
        .busy      (busy)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %h, expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] model(input logic [5:0] o, input logic [31:0] a, input logic [31:0] b);
        logic [63:0] p;
        logic [63:0] sa, ua, sb, ub;
        sa = {{32{a[31]}}, a};
        ua = {32'd0, a};
        sb = {{32{b[31]}}, b};
        ub = {32'd0, b};
        p  = 64'd0;
        case (o)
            6'b000001: begin p = ua * ub; return p[31:0];  end
            6'b000010: begin p = sa * sb; return p[63:32]; end
            6'b000100: begin p = ua * ub; return p[63:32]; end
            6'b001000: begin p = sa * ub; return p[63:32]; end
            6'b010000, 6'b100000: begin
                for (int i = 0; i < 32; i++) begin
                    if (b[i]) p = p ^ (ua << i);
                end
                return o[5] ? p[63:32] : p[31:0];
            end
            default: return 32'd0;
        endcase
    endfunction

    // Drive a request in cycle 0 and hold valid until ready; checks latency, busy, result, and idle after.
    task automatic run_op(input string tag, input logic [5:0] o, input logic [31:0] a,
                          input logic [31:0] b, input logic [31:0] exp, input int lat);
        int cyc;
        logic busy_ok;
        logic seen;
        logic [31:0] want;
        @(negedge g_clk);
        valid = 1'b1; ops = o; rs1 = a; rs2 = b;
        exp_q.push_back(exp);
        cyc = 0; busy_ok = 1'b1; seen = 1'b0;
        while (!seen && cyc < 60) begin
            @(negedge g_clk);
            cyc++;
            if (!busy) busy_ok = 1'b0;
            if (ready) begin
                seen = 1'b1;
                want = (exp_q.size() > 0) ? exp_q.pop_front() : 32'hDEADBEEF;
                check({tag, " result"}, result, want);
                valid = 1'b0;
            end
        end
        check({tag, " latency"}, cyc, lat);
        check({tag, " busy"}, {31'd0, busy_ok}, 32'd1);
        @(negedge g_clk);
        check({tag, " idle"}, {30'd0, busy, ready}, 32'd0);
        ops = 6'd0;
    endtask

    initial begin
        int cyc;
        logic saw_ready;
        logic [5:0]  ro;
        logic [31:0] ra, rb;

        g_resetn = 1'b0; valid = 1'b0; flush = 1'b0; ops = 6'd0; rs1 = 32'd0; rs2 = 32'd0;
        repeat (3) @(negedge g_clk);
        check("reset ready",  {31'd0, ready}, 32'd0);
        check("reset busy",   {31'd0, busy},  32'd0);
        check("reset result", result, 32'd0);
        g_resetn = 1'b1;

        run_op("mul",    6'b000001, 32'd7,        32'd6,        32'h0000002A, 33);
        run_op("mulh",   6'b000010, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000000, 33);
        run_op("mulhu",  6'b000100, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 33);
        run_op("mulhsu", 6'b001000, 32'hFFFFFFFF, 32'd2,        32'hFFFFFFFF, 33);
        run_op("clmul",  6'b010000, 32'd3,        32'd3,        32'h00000005, 33);
        run_op("clmulh", 6'b100000, 32'h80000000, 32'd2,        32'h00000001, 33);
        run_op("noop",   6'b000000, 32'd9,        32'd9,        32'h00000000, 1);
        run_op("twoop",  6'b000011, 32'd9,        32'd9,        32'h00000000, 1);

        for (int k = 0; k < 6; k++) begin
            ro = 6'd1 << k;
            ra = $urandom;
            rb = $urandom;
            run_op("rand", ro, ra, rb, model(ro, ra, rb), 33);
        end

        // Flush during RUN: accept in cycle 0, count = 10 in cycle 11, flush there.
        @(negedge g_clk);
        valid = 1'b1; ops = 6'b000001; rs1 = 32'd100; rs2 = 32'd100;
        saw_ready = 1'b0;
        @(negedge g_clk);
        valid = 1'b0;
        for (int c = 1; c < 11; c++) begin
            if (ready) saw_ready = 1'b1;
            @(negedge g_clk);
        end
        flush = 1'b1;
        check("flush ready", {31'd0, ready}, 32'd0);
        @(negedge g_clk);
        flush = 1'b0;
        check("flush idle", {31'd0, busy}, 32'd0);
        repeat (30) begin
            if (ready) saw_ready = 1'b1;
            @(negedge g_clk);
        end
        check("flush no pulse", {31'd0, saw_ready}, 32'd0);
        run_op("post flush", 6'b000001, 32'd5, 32'd5, 32'h00000019, 33);

        // Flush and valid together in IDLE must not start anything.
        @(negedge g_clk);
        valid = 1'b1; flush = 1'b1; ops = 6'b000001;
        @(negedge g_clk);
        valid = 1'b0; flush = 1'b0;
        check("flush blocks valid", {31'd0, busy}, 32'd0);

        // Reset mid-RUN.
        @(negedge g_clk);
        valid = 1'b1; ops = 6'b000100; rs1 = 32'hFFFF; rs2 = 32'hFFFF;
        @(negedge g_clk);
        valid = 1'b0;
        repeat (14) @(negedge g_clk);
        g_resetn = 1'b0;
        @(negedge g_clk);
        check("rst run ready",  {31'd0, ready}, 32'd0);
        check("rst run busy",   {31'd0, busy},  32'd0);
        check("rst run result", result, 32'd0);
        g_resetn = 1'b1;
        saw_ready = 1'b0;
        cyc = 0;
        while (cyc < 40) begin
            @(negedge g_clk);
            if (ready) saw_ready = 1'b1;
            cyc++;
        end
        check("rst no pulse", {31'd0, saw_ready}, 32'd0);
        check("scoreboard empty", exp_q.size(), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
